// File: rtl/fnd_scan_controller.sv
// Multiplexed seven-segment (FND) scan controller: per-digit prescaled scan with frame-latched shadow data.
// Optional leading-zero blanking is built when FND_LZ_SUPPRESS_EN is defined.
module fnd_scan_controller #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     seg_common,
  output logic                  frame_start
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]         count, count_n;
  logic [IW-1:0]         idx, idx_n;
  logic [4*DIGITS-1:0]   shadow_v, shadow_v_n;
  logic [DIGITS-1:0]     shadow_dp, shadow_dp_n;
  logic [7:0]            seg_n;
  logic [DIGITS-1:0]     common_n;
  logic                  frame_n;
  logic                  tick;
  logic [3:0]            nibble;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // The segment/anode registers are loaded from the *next* index and shadow so that
  // the digit shown always matches the index register with no skew.
  always_comb begin
    count_n     = count;
    idx_n       = idx;
    shadow_v_n  = shadow_v;
    shadow_dp_n = shadow_dp;
    frame_n     = 1'b0;
    tick        = en && (count == CNT_MAX);

    if (en) begin
      count_n = tick ? '0 : count + 1'b1;
      if (tick) begin
        if (idx == IDX_MAX) begin
          idx_n       = '0;
          shadow_v_n  = value;
          shadow_dp_n = dp;
          frame_n     = 1'b1;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
    end

    nibble          = shadow_v_n[4*idx_n +: 4];
    seg_n           = {~shadow_dp_n[idx_n], hex_to_seg(nibble)};
    common_n        = '1;
    common_n[idx_n] = 1'b0;

`ifdef FND_LZ_SUPPRESS_EN
    begin
      logic lz;
      lz = (idx_n != '0);
      for (int j = 0; j < DIGITS; j++) begin
        if ((j >= int'(idx_n)) && (shadow_v_n[4*j +: 4] != 4'h0)) lz = 1'b0;
      end
      if (lz) seg_n[6:0] = 7'h7F;
    end
`endif

    if (!en) begin
      seg_n    = 8'hFF;
      common_n = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count       <= '0;
      idx         <= IDX_MAX;
      shadow_v    <= '0;
      shadow_dp   <= '0;
      seg         <= 8'hFF;
      seg_common  <= '1;
      frame_start <= 1'b0;
    end else begin
      count       <= count_n;
      idx         <= idx_n;
      shadow_v    <= shadow_v_n;
      shadow_dp   <= shadow_dp_n;
      seg         <= seg_n;
      seg_common  <= common_n;
      frame_start <= frame_n;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller (DIGITS=4, CLK_DIV=4): directed scenarios plus random stimulus,
// every cycle compared against a cycle-count based reference model.
module tb_fnd_scan_controller;
  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 4;
`ifdef FND_LZ_SUPPRESS_EN
  localparam logic [7:0] LZ_SEG = 8'hFF;
`else
  localparam logic [7:0] LZ_SEG = 8'hC0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, en;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [7:0]  seg;
  logic [3:0]  seg_common;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  // model state: enabled cycles since reset and the frame-latched data
  int          en_cycles = 0;
  logic [15:0] sh_v  = '0;
  logic [3:0]  sh_dp = '0;
  logic [12:0] exp_q[$];
  logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 clk = ~clk;

  fnd_scan_controller #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .value(value), .dp(dp),
    .seg(seg), .seg_common(seg_common), .frame_start(frame_start)
  );

  task automatic model_edge(input logic rn, input logic e, input logic [15:0] v, input logic [3:0] d);
    int         idx;
    logic [7:0] s;
    logic       fs;
    if (!rn) begin
      en_cycles = 0;
      sh_v      = '0;
      sh_dp     = '0;
      exp_q.push_back({8'hFF, 4'hF, 1'b0});
    end else if (!e) begin
      exp_q.push_back({8'hFF, 4'hF, 1'b0});
    end else begin
      en_cycles++;
      fs  = 1'b0;
      idx = (DIGITS - 1 + en_cycles / CLK_DIV) % DIGITS;
      if ((en_cycles % CLK_DIV == 0) && (idx == 0)) begin
        sh_v  = v;
        sh_dp = d;
        fs    = 1'b1;
      end
      s    = hex_tab[4'(sh_v >> (4 * idx))];
      s[7] = ~sh_dp[idx];
`ifdef FND_LZ_SUPPRESS_EN
      if ((idx > 0) && ((sh_v >> (4 * idx)) == 16'h0)) s[6:0] = 7'h7F;
`endif
      exp_q.push_back({s, ~(4'b0001 << idx), fs});
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic step(input logic rn, input logic e, input logic [15:0] v, input logic [3:0] d);
    logic [12:0] ex;
    reset_n = rn;
    en      = e;
    value   = v;
    dp      = d;
    @(posedge clk);
    model_edge(rn, e, v, d);
    #1;
    ex = exp_q.pop_front();
    chk("seg", seg, ex[12:5]);
    chk("seg_common", {4'h0, seg_common}, {4'h0, ex[4:1]});
    chk("frame_start", {7'h0, frame_start}, {7'h0, ex[0]});
  endtask

  task automatic run(input int n, input logic rn, input logic e, input logic [15:0] v, input logic [3:0] d);
    for (int i = 0; i < n; i++) step(rn, e, v, d);
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; value = '0; dp = '0;

    // reset hold, then first frame
    run(3, 1'b0, 1'b1, 16'h1234, 4'h0);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_common", {4'h0, seg_common}, 8'h0F);
    chk("rst_fs", {7'h0, frame_start}, 8'h00);
    run(4, 1'b1, 1'b1, 16'h1234, 4'h0);
    chk("first_common", {4'h0, seg_common}, 8'h0E);
    chk("first_fs", {7'h0, frame_start}, 8'h01);
    chk("d0_seg", seg, 8'h99);
    run(1, 1'b1, 1'b1, 16'h1234, 4'h0);
    chk("fs_single", {7'h0, frame_start}, 8'h00);
    run(3, 1'b1, 1'b1, 16'h1234, 4'h0);
    chk("d1_common", {4'h0, seg_common}, 8'h0D);
    chk("d1_seg", seg, 8'hB0);

    // value changes mid-frame; digits 2,3 must keep the old frame
    run(4, 1'b1, 1'b1, 16'hABCD, 4'h0);
    chk("tear_d2", seg, 8'hA4);
    run(4, 1'b1, 1'b1, 16'hABCD, 4'h0);
    chk("tear_d3", seg, 8'hF9);
    chk("d3_common", {4'h0, seg_common}, 8'h07);
    run(4, 1'b1, 1'b1, 16'hABCD, 4'h0);
    chk("new_d0", seg, 8'hA1);
    run(4, 1'b1, 1'b1, 16'hABCD, 4'h0);
    chk("new_d1", seg, 8'hC6);
    run(4, 1'b1, 1'b1, 16'hABCD, 4'h0);
    chk("new_d2", seg, 8'h83);

    // enable drop while digit 2 is shown, prescaler mid-count
    run(2, 1'b1, 1'b1, 16'hABCD, 4'h0);
    run(1, 1'b1, 1'b0, 16'hABCD, 4'h0);
    chk("dis_seg", seg, 8'hFF);
    chk("dis_common", {4'h0, seg_common}, 8'h0F);
    run(9, 1'b1, 1'b0, 16'hABCD, 4'h0);
    run(1, 1'b1, 1'b1, 16'hABCD, 4'h0);
    chk("resume_seg", seg, 8'h83);
    chk("resume_common", {4'h0, seg_common}, 8'h0B);
    run(1, 1'b1, 1'b1, 16'hABCD, 4'h0);
    chk("resume_d3", seg, 8'h88);

    // mid-frame reset, then decimal point
    run(1, 1'b0, 1'b1, 16'h2222, 4'b0100);
    chk("midrst_seg", seg, 8'hFF);
    run(4, 1'b1, 1'b1, 16'h2222, 4'b0100);
    chk("dp_d0", seg, 8'hA4);
    run(4, 1'b1, 1'b1, 16'h2222, 4'b0100);
    chk("dp_d1", seg, 8'hA4);
    run(4, 1'b1, 1'b1, 16'h2222, 4'b0100);
    chk("dp_d2", seg, 8'h24);

    // leading zeros
    run(1, 1'b0, 1'b1, 16'h0050, 4'h0);
    run(4, 1'b1, 1'b1, 16'h0050, 4'h0);
    chk("lz_d0", seg, 8'hC0);
    run(4, 1'b1, 1'b1, 16'h0050, 4'h0);
    chk("lz_d1", seg, 8'h92);
    run(4, 1'b1, 1'b1, 16'h0050, 4'h0);
    chk("lz_d2", seg, LZ_SEG);
    run(4, 1'b1, 1'b1, 16'h0050, 4'h0);
    chk("lz_d3", seg, LZ_SEG);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic        rn, e;
      logic [15:0] v;
      rn = ($urandom_range(0, 63) != 0);
      e  = ($urandom_range(0, 7) != 0);
      v  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      step(rn, e, v, 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
